// File: rtl/p1_seq_detector.sv
// Serial Moore detector for the bit pattern 1,0,1,1 (oldest first) on X.
// Y is a registered flag that is high only while the state register holds S4.
//
// state | meaning
// ------+--------------------------------------
// S0    | nothing matched
// S1    | "1" matched
// S2    | "10" matched
// S3    | "101" matched
// S4    | "1011" matched, Y high for this cycle
module p1_seq_detector #(
   parameter bit OVERLAP = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic X,
   output logic Y
);

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } state_t;

   state_t state;
   logic   y_q;

   // y_q is set exactly on the edges that move the FSM into S4, so it always equals (state == S4)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S0;
         y_q   <= 1'b0;
      end else begin
         y_q <= 1'b0;
         case (state)
            S0: state <= X ? S1 : S0;
            S1: state <= X ? S1 : S2;
            S2: state <= X ? S3 : S0;
            S3: begin
               if (X) begin
                  state <= S4;
                  y_q   <= 1'b1;
               end else begin
                  state <= S2;
               end
            end
            S4: begin
               if (X)
                  state <= S1;
               else
                  state <= OVERLAP ? S2 : S0;
            end
            default: state <= S0;
         endcase
      end
   end

   assign Y = y_q;

endmodule

// File: tb/tb_p1_seq_detector.sv
// Bench for p1_seq_detector: runs an OVERLAP=1 and an OVERLAP=0 instance side by side.
// The reference keeps a bit history and flags a detect when the last four bits are 1011.
module tb_p1_seq_detector;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic X     = 1'b0;
   logic y_ov;
   logic y_no;

   p1_seq_detector #(.OVERLAP(1'b1)) dut_ov (.clk(clk), .rst_n(rst_n), .X(X), .Y(y_ov));
   p1_seq_detector #(.OVERLAP(1'b0)) dut_no (.clk(clk), .rst_n(rst_n), .X(X), .Y(y_no));

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // index 0 models OVERLAP=1, index 1 models OVERLAP=0
   logic [3:0] hist  [2];
   int         cnt   [2];
   logic       exp_y [2];

   task automatic check(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got Y=%b expected Y=%b at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         hist[i]  = 4'b0000;
         cnt[i]   = 0;
         exp_y[i] = 1'b0;
      end
   endtask

   // Without overlap, a detection discards the history so no bit is shared between matches.
   task automatic push(input logic b, input string tag);
      X = b;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         hist[i]  = {hist[i][2:0], b};
         cnt[i]   = cnt[i] + 1;
         exp_y[i] = (cnt[i] >= 4) && (hist[i] == 4'b1011);
         if (exp_y[i] && i == 1)
            cnt[i] = 0;
      end
      check({tag, "_ov1"}, y_ov, exp_y[0]);
      check({tag, "_ov0"}, y_no, exp_y[1]);
   endtask

   task automatic push_seq(input logic [15:0] bits, input int len, input string tag);
      logic [15:0] v;
      v = bits;
      for (int i = len - 1; i >= 0; i--)
         push(v[i], tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      check({tag, "_rst_ov1"}, y_ov, 1'b0);
      check({tag, "_rst_ov0"}, y_no, 1'b0);
      repeat (2) begin
         @(posedge clk);
         X = ~X;
         #1;
         check({tag, "_rsthold_ov1"}, y_ov, 1'b0);
         check({tag, "_rsthold_ov0"}, y_no, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      do_reset("init");
      push_seq(16'b0000, 4, "idle");

      do_reset("basic");
      push_seq(16'b10110, 5, "basic");

      do_reset("olap");
      push_seq(16'b1011011, 7, "olap");

      do_reset("twice");
      push_seq(16'b10111011, 8, "twice");

      do_reset("miss1");
      push_seq(16'b1111, 4, "miss1");
      do_reset("miss2");
      push_seq(16'b10011, 5, "miss2");
      do_reset("miss3");
      push_seq(16'b101011, 6, "miss3");

      // asynchronous reset while Y is high must clear it without a clock edge
      do_reset("async");
      push_seq(16'b1011, 4, "async_pre");
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      check("async_drop_ov1", y_ov, 1'b0);
      check("async_drop_ov0", y_no, 1'b0);
      #3 rst_n = 1'b1;
      @(negedge clk);

      // reset after a partial 101 must discard it
      push_seq(16'b101, 3, "partial");
      #4 rst_n = 1'b0;
      model_reset();
      #1;
      check("partial_rst_ov1", y_ov, 1'b0);
      check("partial_rst_ov0", y_no, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      push(1'b1, "after_rst_one");
      push_seq(16'b011, 3, "after_rst_full");

      do_reset("rand");
      repeat (600)
         push(1'($urandom_range(0, 1)), "rand");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
